// File: rtl/abc_producer.sv
// Sending end of the s/h + dav_/rfd handshake: buffers signed step commands in a
// small FIFO and hands each one to the consumer as direction plus step count.
module abc_producer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_delta,
  output logic       cmd_ready,
  input  logic       rfd,
  output logic       dav_,
  output logic       s,
  output logic [6:0] h,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        dav_q, dav_d;
  logic        s_q, s_d;
  logic [6:0]  h_q, h_d;
  logic [7:0]  sent_q, sent_d;

  logic        empty, full, push, pop;
  logic [7:0]  head, head_mag;
  logic [6:0]  head_h;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_mag = head[7] ? (~head + 8'd1) : head;
  // Only -128 yields a magnitude with bit 7 set; it saturates to 127.
  assign head_h   = head_mag[7] ? 7'd127 : head_mag[6:0];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cmd_delta;
    end
  end

  always_comb begin
    state_d = state_q;
    dav_d   = dav_q;
    s_d     = s_q;
    h_d     = h_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head == 8'd0) begin
            pop = 1'b1;
          end else if (rfd) begin
            pop     = 1'b1;
            s_d     = head[7];
            h_d     = head_h;
            dav_d   = 1'b0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          sent_d  = sent_q + 8'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Waiting for rfd to return keeps a steady-high rfd from re-triggering.
        if (rfd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dav_q    <= 1'b1;
      s_q      <= 1'b0;
      h_q      <= 7'd0;
      sent_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dav_q    <= dav_d;
      s_q      <= s_d;
      h_q      <= h_d;
      sent_q   <= sent_d;
    end
  end

  assign dav_     = dav_q;
  assign s        = s_q;
  assign h        = h_q;
  assign sent_cnt = sent_q;
  assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_abc_producer.sv
// Directed bench for abc_producer: a scoreboard of expected (s, h, consumer output)
// is filled as commands are pushed and drained by an in-line model consumer.
module tb_abc_producer;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_delta = 8'd0;
  logic       cmd_ready;
  logic       rfd = 1'b1;
  logic       dav_;
  logic       s;
  logic [6:0] h;
  logic       busy;
  logic [7:0] sent_cnt;

  typedef struct {
    logic       s;
    logic [6:0] h;
    logic [7:0] out;
  } xfer_t;

  xfer_t exp_q[$];
  int    total_cnt = 0;
  int    fail_cnt  = 0;
  int    viol_cnt  = 0;

  abc_producer dut (
    .clock     (clock),
    .reset_    (reset_),
    .cmd_valid (cmd_valid),
    .cmd_delta (cmd_delta),
    .cmd_ready (cmd_ready),
    .rfd       (rfd),
    .dav_      (dav_),
    .s         (s),
    .h         (h),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  always #5 clock = ~clock;

  // dav_ may only fall on an edge where the producer saw rfd high.
  always @(posedge clock) begin
    logic d0, r0;
    d0 = dav_;
    r0 = rfd;
    #1;
    if (d0 === 1'b1 && dav_ === 1'b0 && r0 !== 1'b1) viol_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t model(input logic [7:0] d);
    xfer_t x;
    int mag;
    mag = d[7] ? 256 - int'(d) : int'(d);
    if (mag > 127) mag = 127;
    x.s   = d[7];
    x.h   = mag[6:0];
    x.out = d[7] ? 8'(128 - mag) : 8'(128 + mag);
    return x;
  endfunction

  task automatic do_reset();
    reset_    = 1'b0;
    cmd_valid = 1'b0;
    rfd       = 1'b1;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic push_cmd(input logic [7:0] d, input logic accept);
    check("cmd_ready", 32'(cmd_ready), 32'(accept));
    cmd_valid = 1'b1;
    cmd_delta = d;
    if (accept && d != 8'd0) exp_q.push_back(model(d));
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Model consumer: accepts one transfer, steps from 0x80, then releases rfd.
  task automatic serve_one(input string tag);
    logic       got_s;
    logic [6:0] got_h;
    logic [7:0] out;
    xfer_t      e;
    int         n;
    rfd = 1'b1;
    n = 0;
    while (dav_ !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_dav_fall"}, 32'(dav_), 32'd0);
    if (dav_ !== 1'b0) return;
    got_s = s;
    got_h = h;
    rfd = 1'b0;
    n = 0;
    while (dav_ !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_dav_rise"}, 32'(dav_), 32'd1);
    out = 8'h80;
    for (int i = 0; i < int'(got_h); i++) begin
      @(negedge clock);
      out = got_s ? out - 8'd1 : out + 8'd1;
    end
    check({tag, "_sh_hold"}, {24'd0, s, h}, {24'd0, got_s, got_h});
    rfd = 1'b1;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_xfer"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_s"}, 32'(got_s), 32'(e.s));
    check({tag, "_h"}, 32'(got_h), 32'(e.h));
    check({tag, "_out"}, 32'(out), 32'(e.out));
  endtask

  initial begin
    do_reset();
    check("rst_dav", 32'(dav_), 32'd1);
    check("rst_s", 32'(s), 32'd0);
    check("rst_h", 32'(h), 32'd0);
    check("rst_sent", 32'(sent_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // +5 and first-transfer latency
    push_cmd(8'd5, 1'b1);
    check("lat_k", 32'(dav_), 32'd1);
    @(negedge clock);
    check("lat_k1", 32'(dav_), 32'd0);
    serve_one("p5");
    check("p5_sent", 32'(sent_cnt), 32'd1);
    check("p5_dav_end", 32'(dav_), 32'd1);

    // -3 then -128
    do_reset();
    push_cmd(8'hFD, 1'b1);
    push_cmd(8'h80, 1'b1);
    serve_one("m3");
    serve_one("m128");
    check("neg_sent", 32'(sent_cnt), 32'd2);

    // zero is discarded
    do_reset();
    push_cmd(8'd0, 1'b1);
    check("zero_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_dav", 32'(dav_), 32'd1);
    check("zero_sent", 32'(sent_cnt), 32'd0);
    push_cmd(8'd1, 1'b1);
    serve_one("p1");
    check("p1_sent", 32'(sent_cnt), 32'd1);

    // fill with rfd low; fifth push refused even as a pop occurs
    do_reset();
    rfd = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(8'(i), 1'b1);
    check("full_hold_dav", 32'(dav_), 32'd1);
    rfd = 1'b1;
    push_cmd(8'd5, 1'b0);
    for (int i = 0; i < 4; i++) serve_one("fill");
    repeat (3) @(negedge clock);
    check("fill_sent", 32'(sent_cnt), 32'd4);
    check("fill_busy", 32'(busy), 32'd0);

    // reset while in SEND
    do_reset();
    push_cmd(8'd2, 1'b1);
    push_cmd(8'd3, 1'b1);
    check("mid_in_send", 32'(dav_), 32'd0);
    reset_ = 1'b0;
    #1;
    check("mid_dav", 32'(dav_), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(cmd_ready), 32'd1);
    check("mid_sent", 32'(sent_cnt), 32'd0);
    check("mid_sh", {24'd0, s, h}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    exp_q.delete();
    @(negedge clock);
    push_cmd(8'd2, 1'b1);
    serve_one("post_rst");
    check("post_rst_sent", 32'(sent_cnt), 32'd1);

    // push and pop in the same cycle at DEPTH-1 occupancy
    do_reset();
    rfd = 1'b0;
    push_cmd(8'd10, 1'b1);
    push_cmd(8'd20, 1'b1);
    push_cmd(8'd30, 1'b1);
    rfd = 1'b1;
    push_cmd(8'd40, 1'b1);
    check("pp_dav", 32'(dav_), 32'd0);
    check("pp_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) serve_one("pp");
    check("pp_sent", 32'(sent_cnt), 32'd4);

    // sent_cnt wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push_cmd(8'd1, 1'b1);
      serve_one("wrap");
      if (i == 254) check("wrap_255", 32'(sent_cnt), 32'd255);
    end
    check("wrap_0", 32'(sent_cnt), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("dav_fall_rule", 32'(viol_cnt), 32'd0);

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
